// File: rtl/dmem_pkg.sv
// Shared types and defaults for the MEM-stage data-memory responder.
// The error-check build option is selected by defining DMEM_ERR_CHECK_EN.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } dmem_state_t;

    localparam int DMEM_DATA_W     = 32;
    localparam int DMEM_ADDR_W     = 32;
    localparam int DMEM_MEM_DEPTH  = 1024;
    localparam int DMEM_RD_LAT_MIN = 1;
    localparam int DMEM_RD_LAT_MAX = 3;

    // Out-of-range latencies are pulled to the nearest supported value.
    function automatic int clamp_rd_latency(input int lat);
        if (lat < DMEM_RD_LAT_MIN) return DMEM_RD_LAT_MIN;
        if (lat > DMEM_RD_LAT_MAX) return DMEM_RD_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/dmem_rd_timer.sv
// Loadable down-counter that times the RAM read latency; done is high at zero.
module dmem_rd_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         done
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the MEM-stage data-memory interface; hides synchronous RAM read latency.
// Define DMEM_ERR_CHECK_EN to fault misaligned and out-of-range accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int MEM_DEPTH  = DMEM_MEM_DEPTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic [$clog2(MEM_DEPTH)-1:0] ram_addr,
    output logic [DATA_W-1:0]            ram_data,
    output logic                         ram_wren,
    input  logic [DATA_W-1:0]            ram_q,
    output dmem_state_t                  dbg_state
);

    localparam int AW  = $clog2(MEM_DEPTH);
    localparam int LAT = clamp_rd_latency(RD_LATENCY);
    localparam int CW  = $clog2(LAT + 1);

    // Both handshakes: a transfer occurs on a rising edge where valid and ready are
    // both high; the sender holds its payload stable while valid is high and ready low.

    dmem_state_t   state, state_nxt;
    logic          accept;
    logic          fault;
    logic          timer_load;
    logic          timer_done;
    logic [AW-1:0] word_idx;
    logic [CW-1:0] timer_cnt_unused;

    assign word_idx  = req_addr[2 +: AW];
    assign accept    = req_valid & req_ready;
    assign dbg_state = state;

`ifdef DMEM_ERR_CHECK_EN
    logic [ADDR_W-1:0] word_num;
    assign word_num = req_addr >> 2;
    assign fault    = (req_addr[1:0] != 2'b00) || (word_num >= ADDR_W'(MEM_DEPTH));
`else
    // Byte offset and bits above the RAM index are dropped, so addresses wrap.
    logic addr_unused;
    assign addr_unused = ^{req_addr[1:0], req_addr[ADDR_W-1:2+AW]};
    assign fault       = 1'b0;
`endif

    dmem_rd_timer #(.W(CW)) u_rd_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (CW'(LAT - 1)),
        .dec      (state == RD_WAIT),
        .cnt      (timer_cnt_unused),
        .done     (timer_done)
    );

    always_comb begin
        state_nxt  = state;
        timer_load = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_we || fault) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt  = RD_WAIT;
                        timer_load = 1'b1;
                    end
                end
            end
            RD_WAIT: if (timer_done) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ram_addr  <= '0;
            ram_data  <= '0;
            ram_wren  <= 1'b0;
        end else begin
            state     <= state_nxt;
            req_ready <= (state_nxt == IDLE);
            rsp_valid <= (state_nxt == RESP);
            ram_wren  <= 1'b0;
            if ((state == IDLE) && accept) begin
                rsp_rdata <= '0;
                rsp_err   <= fault;
                if (!fault) begin
                    ram_addr <= word_idx;
                    if (req_we) begin
                        ram_data <= req_wdata;
                        ram_wren <= 1'b1;
                    end
                end
            end
            // Read data is sampled on the edge that leaves RD_WAIT.
            if ((state == RD_WAIT) && timer_done) begin
                rsp_rdata <= ram_q;
            end
        end
    end

endmodule
